// File: rtl/flash_audio_streamer.sv
// Streams PCM samples out of a word-addressed flash region, one sample per tick.
// Several samples can share a 32-bit word, and playback can run forward or in reverse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | issue a read for flsh_address
// REQ    | read held until the flash accepts it (waitrequest low)
// WAITV  | read accepted, waiting for readdatavalid
// READY  | word buffered, samples served on ticks
// DRAIN  | a read was accepted before restart; discard its data
// STOP   | one-shot playback finished, done high
module flash_audio_streamer #(
    parameter int                 ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0,
    parameter logic [ADDR_W-1:0]  END_ADDR   = ADDR_W'(23'h7FFFF),
    parameter int                 SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                pause,
    input  logic                reverse,
    input  logic                loop,
    input  logic                restart,
    output logic [ADDR_W-1:0]   flsh_address,
    output logic                flsh_read,
    input  logic                flsh_waitrequest,
    input  logic [31:0]         flsh_readdata,
    input  logic                flsh_readdatavalid,
    output logic [3:0]          flsh_byteenable,
    output logic [SAMPLE_W-1:0] audio_data,
    output logic                audio_valid,
    output logic                done,
    output logic [15:0]         underrun_count
);

    localparam int SPW   = 32 / SAMPLE_W;
    localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPW - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_REQ, S_WAITV, S_READY, S_DRAIN, S_STOP
    } state_t;

    state_t              state;
    logic [31:0]         word_buf;
    logic [IDX_W-1:0]    idx;
    logic                dir;
    logic                tick_ok;
    logic                at_wrap;
    logic                last_slot;
    logic [ADDR_W-1:0]   next_addr;
    logic [SAMPLE_W-1:0] slot;

    assign flsh_byteenable = 4'hF;
    assign tick_ok         = sample_tick && !pause;
    assign slot            = word_buf[int'(idx)*SAMPLE_W +: SAMPLE_W];
    // dir is latched per word so a direction change only affects the next word
    assign last_slot       = dir ? (idx == '0) : (idx == LAST_IDX);

    always_comb begin
        at_wrap   = reverse ? (flsh_address == START_ADDR) : (flsh_address == END_ADDR);
        next_addr = flsh_address;
        if (reverse)
            next_addr = at_wrap ? END_ADDR : flsh_address - ADDR_W'(1);
        else
            next_addr = at_wrap ? START_ADDR : flsh_address + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_FETCH;
            flsh_address   <= START_ADDR;
            flsh_read      <= 1'b0;
            word_buf       <= '0;
            idx            <= '0;
            dir            <= 1'b0;
            audio_data     <= '0;
            audio_valid    <= 1'b0;
            done           <= 1'b0;
            underrun_count <= '0;
        end else begin
            audio_valid <= 1'b0;
            if (restart) begin
                flsh_address <= reverse ? END_ADDR : START_ADDR;
                flsh_read    <= 1'b0;
                done         <= 1'b0;
                // an accepted read still owes us a readdatavalid unless it lands now
                if ((state == S_WAITV && !flsh_readdatavalid) ||
                    (state == S_DRAIN && !flsh_readdatavalid) ||
                    (state == S_REQ   && !flsh_waitrequest))
                    state <= S_DRAIN;
                else
                    state <= S_FETCH;
            end else begin
                if (tick_ok && state != S_READY && state != S_STOP &&
                    underrun_count != 16'hFFFF)
                    underrun_count <= underrun_count + 16'd1;
                case (state)
                    S_FETCH: begin
                        flsh_read <= 1'b1;
                        state     <= S_REQ;
                    end
                    S_REQ: begin
                        if (!flsh_waitrequest) begin
                            flsh_read <= 1'b0;
                            state     <= S_WAITV;
                        end
                    end
                    S_WAITV: begin
                        if (flsh_readdatavalid) begin
                            word_buf <= flsh_readdata;
                            dir      <= reverse;
                            idx      <= reverse ? LAST_IDX : '0;
                            state    <= S_READY;
                        end
                    end
                    S_READY: begin
                        if (tick_ok) begin
                            audio_data  <= slot;
                            audio_valid <= 1'b1;
                            if (!last_slot) begin
                                idx <= dir ? idx - IDX_W'(1) : idx + IDX_W'(1);
                            end else if (at_wrap && !loop) begin
                                done  <= 1'b1;
                                state <= S_STOP;
                            end else begin
                                flsh_address <= next_addr;
                                state        <= S_FETCH;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (flsh_readdatavalid)
                            state <= S_FETCH;
                    end
                    S_STOP: ;
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_audio_streamer.sv
// Directed bench for flash_audio_streamer: a 16-bit instance over a 4-word region
// with a scripted flash responder, plus an 8-bit instance for reverse slot order.
module tb_flash_audio_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // 16-bit instance, region 0..3
    logic        tick_a = 0, pause_a = 0, rev_a = 0, loop_a = 1, restart_a = 0;
    logic [22:0] addr_a;
    logic        rd_a, wr_a = 0, rdv_a = 0;
    logic [31:0] rdata_a = 0;
    logic [3:0]  be_a;
    logic [15:0] data_a;
    logic        valid_a, done_a;
    logic [15:0] under_a;

    // 8-bit instance, region 0..3, flash always ready
    logic        tick_b = 0, restart_b = 0;
    logic [22:0] addr_b;
    logic        rd_b, rdv_b = 0;
    logic [31:0] rdata_b = 0;
    logic [3:0]  be_b;
    logic [7:0]  data_b;
    logic        valid_b, done_b;
    logic [15:0] under_b;

    logic [31:0] mem_a [4];
    logic [31:0] mem_b [4];
    int          lat_a = 1;
    logic        pend_a = 0;
    logic [1:0]  paddr_a = 0;
    int          cnt_a = 0;

    flash_audio_streamer #(.ADDR_W(23), .START_ADDR(23'd0), .END_ADDR(23'd3), .SAMPLE_W(16)) dut_a (
        .clk(clk), .rst(rst), .sample_tick(tick_a), .pause(pause_a), .reverse(rev_a),
        .loop(loop_a), .restart(restart_a), .flsh_address(addr_a), .flsh_read(rd_a),
        .flsh_waitrequest(wr_a), .flsh_readdata(rdata_a), .flsh_readdatavalid(rdv_a),
        .flsh_byteenable(be_a), .audio_data(data_a), .audio_valid(valid_a),
        .done(done_a), .underrun_count(under_a));

    flash_audio_streamer #(.ADDR_W(23), .START_ADDR(23'd0), .END_ADDR(23'd3), .SAMPLE_W(8)) dut_b (
        .clk(clk), .rst(rst), .sample_tick(tick_b), .pause(1'b0), .reverse(1'b1),
        .loop(1'b1), .restart(restart_b), .flsh_address(addr_b), .flsh_read(rd_b),
        .flsh_waitrequest(1'b0), .flsh_readdata(rdata_b), .flsh_readdatavalid(rdv_b),
        .flsh_byteenable(be_b), .audio_data(data_b), .audio_valid(valid_b),
        .done(done_b), .underrun_count(under_b));

    // responder A: accepts when waitrequest is low, returns data lat_a+1 cycles later
    always @(posedge clk) begin
        rdv_a <= 1'b0;
        if (rst) begin
            pend_a <= 1'b0;
        end else begin
            if (pend_a) begin
                if (cnt_a == 0) begin
                    rdv_a   <= 1'b1;
                    rdata_a <= mem_a[paddr_a];
                    pend_a  <= 1'b0;
                end else begin
                    cnt_a <= cnt_a - 1;
                end
            end
            if (rd_a && !wr_a) begin
                pend_a  <= 1'b1;
                paddr_a <= addr_a[1:0];
                cnt_a   <= lat_a;
            end
        end
    end

    always @(posedge clk) begin
        rdv_b <= 1'b0;
        if (!rst && rd_b) begin
            rdv_b   <= 1'b1;
            rdata_b <= mem_b[addr_b[1:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit b);
        @(negedge clk);
        if (b) tick_b = 1'b1; else tick_a = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        tick_b = 1'b0;
    endtask

    task automatic wait_rdv(input bit b, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b ? rdv_b : rdv_a) && n < 100);
        chk(tag, 32'(b ? rdv_b : rdv_a), 32'd1);
    endtask

    task automatic wait_word(input bit b, input string tag);
        wait_rdv(b, tag);
        @(negedge clk);
    endtask

    task automatic wait_read(input string tag);
        int n = 0;
        while (!rd_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(rd_a), 32'd1);
    endtask

    task automatic tick_expect(input string tag, input logic [15:0] exp);
        tick(1'b0);
        chk({tag, "_valid"}, 32'(valid_a), 32'd1);
        chk({tag, "_data"}, 32'(data_a), 32'(exp));
    endtask

    initial begin
        mem_a[0] = 32'hBBBB_AAAA;
        mem_a[1] = 32'h2222_1111;
        mem_a[2] = 32'h4444_3333;
        mem_a[3] = 32'h6666_5555;
        mem_b[0] = 32'hDDCC_BBAA;
        mem_b[1] = 32'h0;
        mem_b[2] = 32'h0;
        mem_b[3] = 32'h4433_2211;

        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_read", 32'(rd_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_under", 32'(under_a), 32'd0);
        chk("rst_be", 32'(be_a), 32'hF);
        chk("rst_b_be", 32'(be_b), 32'hF);
        chk("rst_b_done", 32'(done_b), 32'd0);
        chk("rst_b_under", 32'(under_b), 32'd0);
        rst = 1'b0;

        // forward, two slots per word, loop through 0..3 and wrap to 0
        wait_word(1'b0, "w0_rdv");
        tick_expect("w0s0", 16'hAAAA);
        tick(1'b0);
        chk("w0s1_data", 32'(data_a), 32'h0000_BBBB);
        chk("w0_next_addr", 32'(addr_a), 32'd1);
        @(negedge clk);
        chk("valid_pulse", 32'(valid_a), 32'd0);
        wait_word(1'b0, "w1_rdv");
        tick_expect("w1s0", 16'h1111);
        tick_expect("w1s1", 16'h2222);
        chk("addr2", 32'(addr_a), 32'd2);
        wait_word(1'b0, "w2_rdv");
        tick_expect("w2s0", 16'h3333);
        tick_expect("w2s1", 16'h4444);
        chk("addr3", 32'(addr_a), 32'd3);
        wait_word(1'b0, "w3_rdv");
        tick_expect("w3s0", 16'h5555);
        tick_expect("w3s1", 16'h6666);
        chk("wrap_addr", 32'(addr_a), 32'd0);

        // pause mid-word
        wait_word(1'b0, "p_rdv");
        tick_expect("p_s0", 16'hAAAA);
        pause_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            chk("pause_valid", 32'(valid_a), 32'd0);
        end
        chk("pause_data", 32'(data_a), 32'h0000_AAAA);
        pause_a = 1'b0;
        tick_expect("p_s1", 16'hBBBB);

        // flash stall with ticks landing in REQ and WAITV
        wr_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_read", 32'(rd_a), 32'd1);
            chk("stall_addr", 32'(addr_a), 32'd1);
            chk("stall_valid", 32'(valid_a), 32'd0);
            tick_a = 1'b1;
        end
        @(negedge clk);
        tick_a = 1'b0;
        wr_a   = 1'b0;
        chk("stall_under5", 32'(under_a), 32'd5);
        tick(1'b0);
        chk("waitv_under6", 32'(under_a), 32'd6);
        chk("waitv_valid", 32'(valid_a), 32'd0);
        chk("underrun_hold_data", 32'(data_a), 32'h0000_BBBB);
        wait_word(1'b0, "s_rdv");
        tick_expect("s_s0", 16'h1111);

        // restart while in WAITV: word 2 must be drained
        lat_a = 3;
        tick_expect("r_s1", 16'h2222);
        wait_read("r_read");
        @(negedge clk);
        chk("r_in_waitv", 32'(rd_a), 32'd0);
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        chk("r_addr", 32'(addr_a), 32'd0);
        chk("r_hold_data", 32'(data_a), 32'h0000_2222);
        wait_rdv(1'b0, "r_old_rdv");
        wait_read("r_refetch");
        chk("r_refetch_addr", 32'(addr_a), 32'd0);
        wait_word(1'b0, "r_new_rdv");
        lat_a = 1;
        tick_expect("r_first", 16'hAAAA);

        // one-shot to the end of the region
        loop_a = 1'b0;
        tick_expect("o_w0s1", 16'hBBBB);
        wait_word(1'b0, "o_w1");
        tick_expect("o_w1s0", 16'h1111);
        tick_expect("o_w1s1", 16'h2222);
        wait_word(1'b0, "o_w2");
        tick_expect("o_w2s0", 16'h3333);
        tick_expect("o_w2s1", 16'h4444);
        wait_word(1'b0, "o_w3");
        tick_expect("o_w3s0", 16'h5555);
        chk("o_not_done", 32'(done_a), 32'd0);
        tick_expect("o_w3s1", 16'h6666);
        chk("o_done", 32'(done_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            chk("stop_valid", 32'(valid_a), 32'd0);
            chk("stop_read", 32'(rd_a), 32'd0);
        end
        chk("stop_under", 32'(under_a), 32'd6);
        chk("stop_done", 32'(done_a), 32'd1);

        // restart in reverse from STOP
        rev_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        chk("rev_done_clr", 32'(done_a), 32'd0);
        chk("rev_addr", 32'(addr_a), 32'd3);
        wait_word(1'b0, "rev_rdv");
        tick_expect("rev_s1", 16'h6666);
        tick_expect("rev_s0", 16'h5555);
        chk("rev_next_addr", 32'(addr_a), 32'd2);

        // 8-bit reverse: four slots from END_ADDR, high byte first
        @(negedge clk);
        restart_b = 1'b1;
        @(negedge clk);
        restart_b = 1'b0;
        wait_word(1'b1, "b_rdv");
        tick(1'b1);
        chk("b_s3_valid", 32'(valid_b), 32'd1);
        chk("b_s3", 32'(data_b), 32'h44);
        tick(1'b1);
        chk("b_s2", 32'(data_b), 32'h33);
        tick(1'b1);
        chk("b_s1", 32'(data_b), 32'h22);
        chk("b_mid_addr", 32'(addr_b), 32'd3);
        tick(1'b1);
        chk("b_s0", 32'(data_b), 32'h11);
        chk("b_next_addr", 32'(addr_b), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/flash_audio_streamer.md
Name: flash_audio_streamer

Overview:
Parametrised successor to the flash-backed music player. Streams PCM samples from a 32-bit Avalon-MM flash region to the audio path, one sample per sample_tick. Adds configurable region bounds, sample width (several samples per flash word), forward/reverse playback, loop or one-shot mode, clean restart with in-flight read drain, and underrun accounting. Sits between the keyboard/control logic and the flash controller; audio_data feeds the audio codec register.

Parameters:
ADDR_W, 23, flash word-address width.
START_ADDR, 0, first word of the audio region (inclusive).
END_ADDR, 23'h7FFFF, last word of the audio region (inclusive); must be >= START_ADDR.
SAMPLE_W, 16, sample width; legal values are 8, 16 and 32. Local SPW = 32/SAMPLE_W samples per word.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
sample_tick  in  1  one-cycle pulse requesting the next sample.
pause  in  1  level; while high, ticks are ignored.
reverse  in  1  0 = forward, 1 = backward playback.
loop  in  1  1 = wrap at region end; 0 = stop and raise done.
restart  in  1  pulse; rewinds to region start for the current direction.
flsh_address  out  ADDR_W  word address to flash.
flsh_read  out  1  read request.
flsh_waitrequest  in  1  flash stall; the request is held while this is high.
flsh_readdata  in  32  read data.
flsh_readdatavalid  in  1  read data qualifier.
flsh_byteenable  out  4  constant 4'hF.
audio_data  out  SAMPLE_W  current sample, registered.
audio_valid  out  1  one-cycle pulse when audio_data updates.
done  out  1  one-shot playback finished.
underrun_count  out  16  ticks that found no buffered word; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - flsh_address = START_ADDR; flsh_read = 0; audio_data = 0; audio_valid = 0; done = 0; underrun_count = 0; idx = 0; state = FETCH.
- Reset behaviour:
  - Reset does not wait for an outstanding read.
  - The flash controller is also reset by rst.
- States:
  - FETCH: drive flsh_read = 1 and go to REQ.
  - REQ: hold flsh_read and flsh_address until a cycle with flsh_waitrequest = 0. Then drop flsh_read next cycle and go to WAITV.
  - WAITV: on flsh_readdatavalid, capture the word into buf and go to READY. Set idx = 0 (forward) or SPW-1 (reverse).
  - READY: word is buffered and samples are served on ticks.
  - DRAIN: an accepted read is outstanding after restart. Discard the next readdatavalid, then go to FETCH.
  - STOP: one-shot playback has ended. done = 1 and ticks are ignored.
- Sample slots:
  - Sample k occupies buf[k*SAMPLE_W +: SAMPLE_W]; k = 0 is the LSBs.
  - Forward order is 0..SPW-1; reverse order is SPW-1..0.
  - Samples are passed through unmodified, with no sign handling.
- Tick in READY with pause = 0:
  - The next cycle, audio_data = buf slot idx and audio_valid = 1 (latency 1).
  - If idx is not the last slot, step idx.
  - Otherwise advance the address and go to FETCH. This prefetches the next word.
- Address advance:
  - Forward: address + 1, or wrap to START_ADDR at END_ADDR.
  - Reverse: address - 1, or wrap to END_ADDR at START_ADDR.
  - At the wrap point with loop = 0, go to STOP instead of fetching.
- Tick in FETCH/REQ/WAITV/DRAIN with pause = 0:
  - Underrun: underrun_count increments (saturating).
  - audio_data holds; audio_valid stays 0.
- Any tick with pause = 1: no effect. Fetches in progress still complete.
- Changing reverse:
  - Takes effect at the next word boundary.
  - The remaining slots of the current word continue in the old order.
- restart (priority over tick in the same cycle):
  - Set address to START_ADDR (reverse = 0) or END_ADDR (reverse = 1), and clear done.
  - If in WAITV, or in REQ in the cycle waitrequest = 0, go to DRAIN. Otherwise go to FETCH; an unaccepted REQ is simply dropped.
  - audio_data holds its value.
- STOP exits only on restart or rst.

Test Plan:
- Forward, SAMPLE_W = 16, word at START_ADDR = 32'hBBBB_AAAA, 2 ticks. Required: audio_data = 16'hAAAA then 16'hBBBB, one audio_valid each; flsh_address then becomes START_ADDR+1.
- Reverse, SAMPLE_W = 8, word at END_ADDR = 32'h44332211, 4 ticks. Required: audio_data = 8'h44, 8'h33, 8'h22, 8'h11; address then becomes END_ADDR-1.
- START_ADDR = 0, END_ADDR = 3, forward, loop = 1, then loop = 0. Required for loop = 1: addresses run 0,1,2,3,0. Required for loop = 0: after the last sample of word 3, done = 1 and further ticks give no audio_valid.
- waitrequest held high 5 cycles, with ticks arriving during REQ/WAITV. Required: flsh_read and flsh_address stable throughout; underrun_count increments per tick; no audio_valid.
- restart while in WAITV, old readdatavalid arriving 3 cycles later. Required: the old word is discarded; the next fetch is at START_ADDR; the first sample after restart comes from START_ADDR data.
- pause = 1 for 10 ticks mid-word. Required: audio_data unchanged and idx unchanged; after release, the next tick outputs the following slot.
